// File: rtl/fc_ims_pkg.sv
// fc_ims_pkg: shared widths, limits and ctrl encodings for the inventory/price block
package fc_ims_pkg;
  localparam int PRICE_W  = 4;
  localparam int QTY_W    = 4;
  localparam int CNT_W    = 4;
  localparam int FPRICE_W = 8;
  localparam int CNT_MAX  = 15;
  typedef enum logic {
    OP_RESTOCK = 1'b0,
    OP_SALE    = 1'b1
  } op_e;
endpackage

// File: rtl/fc_ims_mult4x4.sv
// fc_ims_mult4x4: combinational 4x4 unsigned shift-add multiplier
// Ports: a (unit price), b (quantity), p = a * b as a full-width product
module fc_ims_mult4x4
  import fc_ims_pkg::*;
(
  input  logic [PRICE_W-1:0]  a,
  input  logic [QTY_W-1:0]    b,
  output logic [FPRICE_W-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < QTY_W; i++)
      p = p + (b[i] ? (FPRICE_W'(a) << i) : FPRICE_W'(0));
  end
endmodule

// File: rtl/fc_ims.sv
// fc_ims: one-cycle registered transaction price and saturating stock update
// Ports: clk, rst (async, active-high); ctrl (0 restock, 1 sale);
//   uprice0..3, ncel0..3, ct0..3 scalar inputs (bit 0 = LSB);
//   fprice0..7 = uprice*ncel, new_ct0..3 = updated count, both registered
module fc_ims
  import fc_ims_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ctrl,
  input  logic uprice0, input logic uprice1, input logic uprice2, input logic uprice3,
  input  logic ncel0,   input logic ncel1,   input logic ncel2,   input logic ncel3,
  input  logic ct0,     input logic ct1,     input logic ct2,     input logic ct3,
  output logic fprice0, output logic fprice1, output logic fprice2, output logic fprice3,
  output logic fprice4, output logic fprice5, output logic fprice6, output logic fprice7,
  output logic new_ct0, output logic new_ct1, output logic new_ct2, output logic new_ct3
);
  logic [PRICE_W-1:0]  uprice;
  logic [QTY_W-1:0]    ncel;
  logic [CNT_W-1:0]    ct;
  logic [CNT_W:0]      sum;
  logic [FPRICE_W-1:0] fprice_d, fprice_q;
  logic [CNT_W-1:0]    new_ct_d, new_ct_q;
  assign uprice = {uprice3, uprice2, uprice1, uprice0};
  assign ncel   = {ncel3, ncel2, ncel1, ncel0};
  assign ct     = {ct3, ct2, ct1, ct0};
  fc_ims_mult4x4 u_mult (.a(uprice), .b(ncel), .p(fprice_d));
  // Extra carry bit detects restock overflow so the count can clamp.
  assign sum = {1'b0, ct} + {1'b0, ncel};
  always_comb
    new_ct_d = (ctrl == OP_SALE) ? ((ncel > ct) ? '0 : ct - ncel)
                                 : (sum[CNT_W] ? CNT_W'(CNT_MAX) : sum[CNT_W-1:0]);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fprice_q <= '0;
      new_ct_q <= '0;
    end else begin
      fprice_q <= fprice_d;
      new_ct_q <= new_ct_d;
    end
  assign {fprice7, fprice6, fprice5, fprice4, fprice3, fprice2, fprice1, fprice0} = fprice_q;
  assign {new_ct3, new_ct2, new_ct1, new_ct0} = new_ct_q;
endmodule

// File: tb/tb_fc_ims.sv
// tb_fc_ims: scoreboard bench for fc_ims with directed corners and random traffic
module tb_fc_ims;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ctrl = 1'b0;
  logic [3:0] uprice = '0, ncel = '0, ct = '0;
  logic [7:0] fprice;
  logic [3:0] new_ct;
  int errors = 0;
  int checks = 0;
  typedef struct { int fp; int nc; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  fc_ims dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
    .uprice0(uprice[0]), .uprice1(uprice[1]), .uprice2(uprice[2]), .uprice3(uprice[3]),
    .ncel0(ncel[0]), .ncel1(ncel[1]), .ncel2(ncel[2]), .ncel3(ncel[3]),
    .ct0(ct[0]), .ct1(ct[1]), .ct2(ct[2]), .ct3(ct[3]),
    .fprice0(fprice[0]), .fprice1(fprice[1]), .fprice2(fprice[2]), .fprice3(fprice[3]),
    .fprice4(fprice[4]), .fprice5(fprice[5]), .fprice6(fprice[6]), .fprice7(fprice[7]),
    .new_ct0(new_ct[0]), .new_ct1(new_ct[1]), .new_ct2(new_ct[2]), .new_ct3(new_ct[3])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the transaction rules.
  function automatic exp_t model(input int c, input int u, input int n, input int t);
    exp_t e;
    e.fp = u * n;
    if (c == 0) e.nc = (t + n > 15) ? 15 : t + n;
    else        e.nc = (n > t) ? 0 : t - n;
    return e;
  endfunction

  task automatic drive(input int c, input int u, input int n, input int t, input bit push);
    @(negedge clk);
    ctrl   = c[0];
    uprice = u[3:0];
    ncel   = n[3:0];
    ct     = t[3:0];
    if (push) q.push_back(model(c, u, n, t));
  endtask

  // Monitor: every edge that captured a scored transaction is compared just after.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fprice", int'(fprice), e.fp);
      chk("new_ct", int'(new_ct), e.nc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_fprice", int'(fprice), 0);
    chk("reset_new_ct", int'(new_ct), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 8, 3, 0, 1);
    drive(0, 8, 3, 3, 1);
    drive(1, 8, 4, 6, 1);
    drive(0, 3, 5, 14, 1);
    drive(1, 7, 5, 2, 1);
    drive(0, 15, 15, 0, 1);
    drive(1, 15, 15, 15, 1);
    drive(0, 9, 0, 6, 1);
    drive(1, 9, 0, 6, 1);
    drive(0, 0, 7, 4, 1);
    drive(1, 0, 3, 4, 1);
    drive(1, 5, 4, 4, 1);
    // In-flight transaction discarded by a mid-cycle async reset.
    drive(0, 12, 11, 2, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_fprice", int'(fprice), 0);
    chk("async_rst_new_ct", int'(new_ct), 0);
    @(posedge clk);
    #1;
    chk("held_rst_fprice", int'(fprice), 0);
    chk("held_rst_new_ct", int'(new_ct), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 6, 2, 9, 1);
    for (int k = 0; k < 200; k++)
      drive(int'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(15)), 1);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fc_ims.md
FC_IMS -- requirements
Module: fc_ims

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ctrl  input  1  operation select: 0 = restock (add), 1 = sale (subtract).
REQ-005 uprice0..uprice3  input  1 each  4-bit unsigned unit price; index 0 = LSB.
REQ-006 ncel0..ncel3  input  1 each  4-bit unsigned item quantity for this transaction; index 0 = LSB.
REQ-007 ct0..ct3  input  1 each  4-bit unsigned current stock count; index 0 = LSB.
REQ-008 fprice0..fprice7  output  1 each  8-bit unsigned transaction price; index 0 = LSB.
REQ-009 new_ct0..new_ct3  output  1 each  4-bit unsigned updated stock count; index 0 = LSB.
REQ-010 Port order SHALL be clk, rst, ctrl, uprice0..3, ncel0..3, ct0..3, fprice0..7, new_ct0..3.

Function
REQ-011 Inputs SHALL be sampled on every rising clk edge; no handshake; one transaction per cycle.
REQ-012 Outputs SHALL be registered with a latency of exactly 1 cycle from input sampling.
REQ-013 fprice SHALL equal uprice × ncel as a full 8-bit unsigned product, for both values of ctrl (max 15×15 = 225, no overflow).
REQ-014 When ctrl = 0, new_ct SHALL equal ct + ncel, saturating at 15.
REQ-015 When ctrl = 1 and ncel ≤ ct, new_ct SHALL equal ct − ncel.
REQ-016 When ctrl = 1 and ncel > ct (underflow), new_ct SHALL be 0.
REQ-017 When ctrl = 1 and ncel > ct, fprice SHALL still equal uprice × ncel.
REQ-018 ncel = 0 SHALL give fprice = 0 and new_ct = ct for either ctrl value.
REQ-019 uprice = 0 SHALL give fprice = 0; the count update SHALL be unaffected.
REQ-020 The block SHALL hold no state other than the output registers.

Reset
REQ-021 While rst = 1, all fprice and new_ct bits SHALL be 0 immediately, independent of clk.
REQ-022 Assertion of rst mid-operation SHALL discard the in-flight result.
REQ-023 The first rising edge after rst deasserts SHALL capture inputs normally.

Structure
REQ-024 A shared package SHALL define the constants PRICE_W = 4, QTY_W = 4, CNT_W = 4, FPRICE_W = 8 and CNT_MAX = 15.
REQ-025 The same shared package SHALL define the ctrl encodings OP_RESTOCK = 0 and OP_SALE = 1.
REQ-026 The scalar ports SHALL be packed internally into vectors.
REQ-027 The 4×4 unsigned multiplier SHALL be one sub-module, fc_ims_mult4x4, implemented combinationally with shift-add partial products.
REQ-028 The saturating add/subtract and the output registers SHALL reside in the top-level module.

Verification
REQ-029 Restock from empty: uprice = 8, ncel = 3, ct = 0, ctrl = 0 -> next cycle fprice = 24, new_ct = 3.
REQ-030 Restock from non-empty: uprice = 8, ncel = 3, ct = 3, ctrl = 0 -> fprice = 24, new_ct = 6.
REQ-031 Sale: uprice = 8, ncel = 4, ct = 6, ctrl = 1 -> fprice = 32, new_ct = 2.
REQ-032 Saturation and underflow: ct = 14, ncel = 5, ctrl = 0 -> new_ct = 15; then ct = 2, ncel = 5, ctrl = 1 -> new_ct = 0, fprice = 5 × uprice.
REQ-033 Maximum price: uprice = 15, ncel = 15 -> fprice = 225.
REQ-034 Asynchronous reset: assert rst between clock edges while outputs are non-zero -> all outputs 0 before the next edge.
